// File: rtl/mem_responder.sv
// Unified 32x8 instruction/data memory serving one access at a time.
// Define MEM_WP_EN to write-protect words 0..15 and report data_err.
module mem_responder #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch_req,
    input  logic [4:0] fetch_addr,
    output logic [7:0] instruction,
    output logic       fetch_ack,
    input  logic       data_req,
    input  logic       data_we,
    input  logic [4:0] data_addr,
    input  logic [7:0] data_wdata,
    output logic [7:0] data_rdata,
    output logic       data_ack,
    output logic       data_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] WLOAD = 2'(WAIT_CYCLES - 1);

    state_t     state_q;
    logic [1:0] cnt_q;
    logic       data_q;
    logic       we_q;
    logic [4:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] instr_q;
    logic [7:0] rdata_q;
    logic       fack_q;
    logic       dack_q;
    logic       derr_q;
    logic [7:0] mem_q [32];
    logic       wp_hit;

`ifdef MEM_WP_EN
    assign wp_hit = ~addr_q[4];
`else
    assign wp_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            instr_q <= '0;
            rdata_q <= '0;
            fack_q  <= 1'b0;
            dack_q  <= 1'b0;
            derr_q  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fack_q <= 1'b0;
            dack_q <= 1'b0;
            derr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Data port wins; a held fetch is taken on the next IDLE.
                    if (data_req || fetch_req) begin
                        data_q  <= data_req;
                        we_q    <= data_req & data_we;
                        addr_q  <= data_req ? data_addr : fetch_addr;
                        wdata_q <= data_wdata;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= WLOAD;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (!data_q) begin
                        instr_q <= mem_q[addr_q];
                        fack_q  <= 1'b1;
                    end else begin
                        dack_q <= 1'b1;
                        if (we_q) begin
                            if (wp_hit) begin
                                derr_q <= 1'b1;
                            end else begin
                                mem_q[addr_q] <= wdata_q;
                            end
                        end else begin
                            rdata_q <= mem_q[addr_q];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instruction = instr_q;
    assign fetch_ack   = fack_q;
    assign data_rdata  = rdata_q;
    assign data_ack    = dack_q;
    assign data_err    = derr_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, sets extra wait states per access; legal range 0..3.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 fetch_req  input  1  processor instruction fetch request, held high until fetch_ack.
REQ-005 fetch_addr  input  5  word address of the instruction (PC), held stable until fetch_ack.
REQ-006 instruction  output  8  fetched instruction word, {opcode[7:5], operand[4:0]}.
REQ-007 fetch_ack  output  1  one-cycle pulse; instruction is valid in that cycle.
REQ-008 data_req  input  1  processor data access request, held high until data_ack.
REQ-009 data_we  input  1  1 = store, 0 = load; held stable until data_ack.
REQ-010 data_addr  input  5  data word address, held stable until data_ack.
REQ-011 data_wdata  input  8  store data, driven from processor data_out.
REQ-012 data_rdata  output  8  load data, driven to processor data_in.
REQ-013 data_ack  output  1  one-cycle pulse; the access is complete and data_rdata is valid for loads.
REQ-014 data_err  output  1  write-protect violation flag; present only with MEM_WP_EN, otherwise tied 0.

Function
REQ-015 Storage SHALL be one unified 32 x 8 array shared by the fetch and data ports.
REQ-016 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-017 In IDLE with any request high, the FSM SHALL latch port, address, we and wdata, and go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-018 WAIT SHALL count down WAIT_CYCLES cycles and then go to RESP.
REQ-019 RESP SHALL perform the array read or write, pulse the matching ack for exactly one cycle, and return to IDLE.
REQ-020 Latency from the request being sampled in IDLE to ack SHALL be 1+WAIT_CYCLES cycles; back-to-back throughput is one access per 2+WAIT_CYCLES cycles.
REQ-021 If data_req and fetch_req are both high in IDLE, data SHALL win; the fetch is served next, and a fetch of a just-written address SHALL return the new value.
REQ-022 Only one access SHALL be outstanding; requests arriving in WAIT or RESP are ignored until IDLE.
REQ-023 A request dropped before its ack SHALL still complete; its ack is still issued.
REQ-024 A store SHALL write the array in the RESP cycle; data_rdata SHALL hold its previous value on store acks.
REQ-025 instruction and data_rdata SHALL be registered and hold their values between acks.
REQ-026 Addresses SHALL be exactly 5 bits; no wrap or range logic is needed.

Reset
REQ-027 When rst is high at a clock edge: FSM to IDLE, wait counter 0, fetch_ack=0, data_ack=0, data_err=0, instruction=8'h00, data_rdata=8'h00, all 32 array words 8'h00.
REQ-028 Reset during WAIT or RESP SHALL abort the access: no write occurs and no ack is issued.
REQ-029 rst SHALL take priority over every request in the same cycle.

Configuration
REQ-030 Macro MEM_WP_EN defined: addresses 0..15 are the write-protected program region; a store there SHALL leave the array unchanged and pulse data_err together with data_ack.
REQ-031 Macro MEM_WP_EN undefined: all 32 addresses are writable and data_err is constant 0.

Verification
REQ-032 Reset, then data store addr 5'd10 = 8'hA5 (WP off) -> data_ack after 1 cycle; a load from 10 returns 8'hA5.
REQ-033 fetch_req and data store to addr 3 = 8'h62 raised in the same cycle -> data_ack first; then fetch_ack with instruction=8'h62.
REQ-034 WAIT_CYCLES=3, load from addr 12 -> data_ack exactly 4 cycles after the request is sampled.
REQ-035 With MEM_WP_EN, store 8'hFF to addr 2 -> data_ack and data_err pulse together; a fetch from 2 returns 8'h00. A store to addr 20 succeeds with data_err=0.
REQ-036 rst asserted in WAIT of a store to addr 11 -> no ack is issued and addr 11 reads 8'h00 afterwards.
REQ-037 data_req dropped one cycle after being sampled -> data_ack is still issued once, and the FSM returns to IDLE.
